// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared CPU header: register indices, HI/LO op codes, FSM states
// Purpose: constants shared by the multiply/divide unit and the rest of the core.
// Contents: register file indices, mult/div op codes, FSM state constants,
//           latched operation context struct.
package mult_div_unit_pkg;

    // Register file indices used elsewhere in the core
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Multiply/divide operation codes
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // Multiply/divide FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Context captured when an operation is accepted
    typedef struct packed {
        logic       is_div;   // divide path selected
        logic       neg_lo;   // negate low half (quotient / product)
        logic       neg_hi;   // negate high half (remainder / product)
        logic       div_zero; // divide by zero: result write suppressed
    } md_ctx_t;

endpackage

// File: rtl/mult_div_unit_step.sv
// rtl/mult_div_unit_step.sv - one radix-2 multiply/divide iteration (combinational)
// Purpose: single shift-add (multiply) or restoring subtract-shift (divide) step.
// Ports:
//   acc      in  64  accumulator: multiply {partial, multiplier}; divide {remainder, dividend}
//   operand  in  32  multiplicand (multiply) or divisor (divide) magnitude
//   is_div   in  1   select the divide step
//   acc_next out 64  accumulator after one iteration
module md_step (
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_sub;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole 65-bit value right.
        sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

        // Divide: shifted remainder is at most 33 bits; when it is not below
        // the divisor the difference always fits back into 32 bits.
        rem_sh  = acc[63:31];
        fits    = (rem_sh >= {1'b0, operand});
        rem_sub = rem_sh[31:0] - operand;

        if (is_div) begin
            if (fits)
                acc_next = {rem_sub, acc[30:0], 1'b1};
            else
                acc_next = {acc[62:0], 1'b0};
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Purpose: MULT/MULTU/DIV/DIVU in 32 radix-2 iterations, plus mthi/mtlo moves.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, op           begin operation (sampled in IDLE only), op code
//   src_a, src_b        rs / rt operands
//   mthi, mtlo          write src_a into hi / lo while idle
//   busy                operation in flight
//   done                one-cycle pulse when hi/lo take a result
//   div_by_zero         pulses with done for a divide by zero
//   hi_reg, lo_reg      architectural HI/LO
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] operand;
    md_ctx_t     ctx;
    logic [63:0] acc_next;

    // Operand preparation for the accepting edge
    logic        in_signed;
    logic        in_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        in_div_zero;
    md_ctx_t     ctx_in;

    // Sign correction at FIN
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    md_step u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (ctx.is_div),
        .acc_next (acc_next)
    );

    always_comb begin
        in_signed   = (op == OP_MULT) || (op == OP_DIV);
        in_div      = (op == OP_DIV) || (op == OP_DIVU);
        a_neg       = in_signed & src_a[31];
        b_neg       = in_signed & src_b[31];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        mag_a       = a_neg ? (~src_a + 32'd1) : src_a;
        mag_b       = b_neg ? (~src_b + 32'd1) : src_b;
        in_div_zero = in_div && (src_b == 32'd0);

        ctx_in.is_div   = in_div;
        ctx_in.neg_lo   = a_neg ^ b_neg;
        // Remainder follows the dividend; a product's high half follows the product.
        ctx_in.neg_hi   = in_div ? a_neg : (a_neg ^ b_neg);
        ctx_in.div_zero = in_div_zero;
    end

    always_comb begin
        prod_fix = ctx.neg_lo ? (~acc + 64'd1) : acc;
        quot_fix = ctx.neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = ctx.neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (ctx.is_div) begin
            fin_hi = rem_fix;
            fin_lo = quot_fix;
        end else begin
            fin_hi = prod_fix[63:32];
            fin_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            acc         <= 64'd0;
            operand     <= 32'd0;
            ctx         <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctx <= ctx_in;
                        if (in_div_zero) begin
                            // Nothing to iterate: go straight to FIN to flag it.
                            state <= ST_FIN;
                        end else begin
                            acc     <= in_div ? {32'd0, mag_a} : {32'd0, mag_b};
                            operand <= in_div ? mag_b : mag_a;
                            cnt     <= 5'd31;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end else begin
                        if (mthi)
                            hi_reg <= src_a;
                        if (mtlo)
                            lo_reg <= src_a;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (ctx.div_zero) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        hi_reg <= fin_hi;
                        lo_reg <= fin_lo;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on posedge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  begin op; sampled only in IDLE.
REQ-004 SHALL have: op  in  2  operation, encoded as MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-005 SHALL have: src_a  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-006 SHALL have: src_b  in  32  rt operand (divisor / multiplier).
REQ-007 SHALL have: mthi, mtlo  in  1 each  write src_a into hi / lo.
REQ-008 SHALL have: busy  out  1  op in flight; pipeline stalls mfhi/mflo/mult/div on it.
REQ-009 SHALL have: done  out  1  one-cycle pulse when hi/lo take a result.
REQ-010 SHALL have: div_by_zero  out  1  pulses with done when a DIV/DIVU had src_b=0.
REQ-011 SHALL have: hi_reg, lo_reg  out  32 each  architectural HI/LO, fed to the register file.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE, with encodings taken from the shared header.
REQ-013 SHALL, in IDLE with start=1 and src_b!=0 or op multiply, latch magnitudes (abs for signed ops), the result signs and op, set cnt=31, and go to RUN with busy=1 from the next cycle.
REQ-014 SHALL, in RUN, perform one radix-2 iteration per cycle (shift-add multiply / restoring divide), decrement cnt, and go to FIN after the iteration at cnt=0, giving exactly 32 iterations.
REQ-015 SHALL, in FIN, sign-correct and write hi_reg/lo_reg, drive done=1 and busy=0 for the following cycle, and return to IDLE.
REQ-016 SHALL produce a latency of 33 cycles: start sampled at edge k gives results visible and done high after edge k+33.
REQ-017 SHALL produce multiply results as {hi,lo} = full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-018 SHALL produce divide results as lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give lo=0x80000000 and hi=0 with no flag.
REQ-020 SHALL, for DIV/DIVU with src_b=0, skip RUN (IDLE->FIN), leave hi/lo unchanged, and pulse div_by_zero with done after edge k+1.
REQ-021 SHALL, in IDLE, let mthi/mtlo write src_a into hi/lo at the edge; both asserted together write both.
REQ-022 SHALL, when start and mthi/mtlo are asserted together in IDLE, give start priority and ignore the move.
REQ-023 SHALL ignore start, mthi and mtlo while busy=1 or in FIN.
REQ-024 SHALL hold hi_reg/lo_reg at their previous values throughout RUN.
REQ-025 SHALL sample src_a/src_b/op only at the accepting edge; later changes have no effect.

Reset
REQ-026 SHALL, on rst=1 at a posedge, set state=IDLE, cnt=0, busy=0, done=0, div_by_zero=0, hi_reg=0, lo_reg=0.
REQ-027 SHALL apply reset during RUN/FIN by abandoning the op, with no done pulse.
REQ-028 SHALL give rst priority over start, mthi and mtlo in the same cycle.

Structure
REQ-029 SHALL take op codes and FSM state constants from the shared CPU header, alongside existing register indices.
REQ-030 SHALL contain one natural sub-module, md_step, a combinational single iteration for both the add-shift and subtract-shift paths, instanced once.
REQ-031 SHALL keep the iterative datapath to one 64-bit accumulator plus one 32-bit operand register, with no 32x32 array multiplier.

Verification
REQ-032 SHALL check that MULTU 0xFFFFFFFF x 0xFFFFFFFF gives hi=0xFFFFFFFE and lo=0x00000001, with done exactly 33 cycles after start and busy high for 33 cycles.
REQ-033 SHALL check that MULT -3 x 7 gives hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-034 SHALL check that DIV -7/2 gives lo=0xFFFFFFFD and hi=0xFFFFFFFF, and that DIVU 7/2 gives lo=3 and hi=1.
REQ-035 SHALL check that mthi=0x11 and mtlo=0x22 followed by DIV x/0 gives hi=0x11, lo=0x22 and div_by_zero=1 with done one cycle after start.
REQ-036 SHALL check that DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000 and hi=0, and that start re-asserted mid-op is ignored (single done).
REQ-037 SHALL check that rst asserted at RUN cycle 10 gives busy=0, hi=lo=0 and no done after the next edge, and that a fresh MULTU 2x3 then gives lo=6 and hi=0.
